lemmings_crowd_ctrl: RTL

Controller for a crowd of four Lemmings-style walkers that share one digging tool. Each lemming runs its own walk/fall/dig/splat state machine. A round-robin arbiter makes sure at most one lemming holds the dig tool at any time. The block sits between the per-lemming environment sensors (bump, ground) plus dig requests and the crowd display/scoring logic.

---
 rtl/lemmings_crowd_ctrl_if.sv | 25 ++
 rtl/lemmings_crowd_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/lemmings_crowd_ctrl_if.sv
// Sensor, request and display signals between the lemming environment and the crowd controller.
// The master modport is the environment side; the slave modport is the controller side.
interface lemmings_crowd_ctrl_if;
  logic [3:0] bump_left;
  logic [3:0] bump_right;
  logic [3:0] ground;
  logic [3:0] dig_req;
  logic [3:0] walk_left;
  logic [3:0] walk_right;
  logic [3:0] aaah;
  logic [3:0] digging;
  logic [3:0] splat;
  logic       dig_busy;
  logic [1:0] dig_owner;

  modport master (
    output bump_left, bump_right, ground, dig_req,
    input  walk_left, walk_right, aaah, digging, splat, dig_busy, dig_owner
  );

  modport slave (
    input  bump_left, bump_right, ground, dig_req,
    output walk_left, walk_right, aaah, digging, splat, dig_busy, dig_owner
  );
endinterface

// File: rtl/lemmings_crowd_ctrl.sv
// Four Lemmings walkers sharing one dig tool through a round-robin arbiter.
// Moore outputs one cycle after the sampled inputs; a dig request is only granted while the tool is free, never queued.
module lemmings_crowd_ctrl #(
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  lemmings_crowd_ctrl_if.slave bus
);
  typedef enum logic [2:0] {WL, WR, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_LIMIT);

  state_t           state        [4];
  state_t           state_nxt    [4];
  logic [CNT_W-1:0] fall_cnt     [4];
  logic [CNT_W-1:0] fall_cnt_nxt [4];

  logic [1:0] last_grant;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic [3:0] eligible;
  logic [3:0] grant;

  logic [3:0] walk_left;
  logic [3:0] walk_right;
  logic [3:0] aaah;
  logic [3:0] digging;
  logic [3:0] splat;
  logic       dig_busy;
  logic [1:0] dig_owner;

  // Arbiter: eligibility uses the registered busy flag, so a hand-off always leaves one idle cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = (state[i] == WL || state[i] == WR) && bus.ground[i] &&
                    bus.dig_req[i] && !dig_busy;
    end
  end

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    winner = last_grant;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        winner      = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= WL;
        fall_cnt[i] <= '0;
      end
      last_grant <= 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= state_nxt[i];
        fall_cnt[i] <= fall_cnt_nxt[i];
      end
      if (found) begin
        last_grant <= winner;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i]    = state[i];
      fall_cnt_nxt[i] = '0;
      case (state[i])
        WL: begin
          if (!bus.ground[i])        state_nxt[i] = FALL_L;
          else if (grant[i])         state_nxt[i] = DIG_L;
          else if (bus.bump_left[i]) state_nxt[i] = WR;
        end
        WR: begin
          if (!bus.ground[i])         state_nxt[i] = FALL_R;
          else if (grant[i])          state_nxt[i] = DIG_R;
          else if (bus.bump_right[i]) state_nxt[i] = WL;
        end
        FALL_L, FALL_R: begin
          if (!bus.ground[i]) begin
            fall_cnt_nxt[i] = (fall_cnt[i] >= LIMIT) ? LIMIT : fall_cnt[i] + 1'b1;
          end else if (fall_cnt[i] >= LIMIT) begin
            state_nxt[i] = SPLAT;
          end else begin
            state_nxt[i] = (state[i] == FALL_L) ? WL : WR;
          end
        end
        DIG_L: if (!bus.ground[i]) state_nxt[i] = FALL_L;
        DIG_R: if (!bus.ground[i]) state_nxt[i] = FALL_R;
        default: state_nxt[i] = state[i];
      endcase
    end
  end

  always_comb begin
    walk_left  = '0;
    walk_right = '0;
    aaah       = '0;
    digging    = '0;
    splat      = '0;
    dig_owner  = '0;
    for (int i = 0; i < 4; i++) begin
      walk_left[i]  = (state[i] == WL);
      walk_right[i] = (state[i] == WR);
      aaah[i]       = (state[i] == FALL_L) || (state[i] == FALL_R);
      digging[i]    = (state[i] == DIG_L) || (state[i] == DIG_R);
      splat[i]      = (state[i] == SPLAT);
      if (digging[i]) begin
        dig_owner = 2'(i);
      end
    end
    dig_busy = |digging;
  end

  assign bus.walk_left  = walk_left;
  assign bus.walk_right = walk_right;
  assign bus.aaah       = aaah;
  assign bus.digging    = digging;
  assign bus.splat      = splat;
  assign bus.dig_busy   = dig_busy;
  assign bus.dig_owner  = dig_owner;
endmodule
